// File: rtl/acc8bit_ctrl.sv
// Sequencer for an external accumulator: loads din, adds it count more times, strobes done.
// Latency start->done = count+2 cycles; start is ignored while busy (no queueing, no backpressure).
module acc8bit_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNTW-1:0]  count,
  input  logic [WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0] acc_d,
  output logic             ldacc,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_reg;
  logic [CNTW-1:0]  cnt_reg;
  logic [WIDTH:0]   sum;

  // Extra bit carries the carry-out used for the sticky overflow flag.
  assign sum = {1'b0, acc_q} + {1'b0, op_reg};

  always_comb begin
    state_nxt = state;
    acc_d     = '0;
    ldacc     = 1'b0;
    en        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        en        = 1'b1;
        ldacc     = 1'b1;
        acc_d     = op_reg;
        busy      = 1'b1;
        state_nxt = (cnt_reg == '0) ? DONE : ADD;
      end
      ADD: begin
        en    = 1'b1;
        ldacc = 1'b1;
        acc_d = sum[WIDTH-1:0];
        busy  = 1'b1;
        if (cnt_reg == CNTW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_reg  <= '0;
      cnt_reg <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_reg  <= din;
            cnt_reg <= count;
            ovf     <= 1'b0;
          end
        end
        ADD: begin
          cnt_reg <= cnt_reg - 1'b1;
          ovf     <= ovf | sum[WIDTH];
        end
        default: ;
      endcase
      // Capture the value being written on the final step so result is valid alongside done.
      if (state_nxt == DONE && state != DONE) result <= acc_d;
    end
  end

endmodule

// File: tb/tb_acc8bit_ctrl.sv
// Directed bench for acc8bit_ctrl with a behavioural accumulator register on the feedback path.
module tb_acc8bit_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] din;
  logic [3:0] count;
  logic [7:0] acc_q = '0;
  logic [7:0] acc_d, result;
  logic       ldacc, en, busy, done, ovf;

  int checks = 0;
  int errors = 0;
  int done_cyc, busy_cyc, ld_cyc;
  logic [7:0] acc_hist [0:40];

  acc8bit_ctrl #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .count(count),
    .acc_q(acc_q), .acc_d(acc_d), .ldacc(ldacc), .en(en),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (en && ldacc) acc_q <= acc_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start from the current cycle, then records per-cycle observations until done.
  task automatic run_job(input logic [7:0] d, input logic [3:0] n);
    start = 1'b1; din = d; count = n;
    tick();
    start = 1'b0; din = 8'($urandom); count = 4'($urandom);
    done_cyc = -1; busy_cyc = 0; ld_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      acc_hist[c] = acc_q;
      if (busy) busy_cyc++;
      if (ldacc && en) ld_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL job_timeout: done not seen within 40 cycles (din=%0d count=%0d)", d, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = '0; count = '0;
    tick(); tick();
    checks++;
    if ({busy, done, ldacc, en, ovf} !== 5'b0 || result !== 8'd0 || acc_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b ldacc=%b en=%b ovf=%b result=%0d acc_d=%0d, required all 0",
               busy, done, ldacc, en, ovf, result, acc_d);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_q [0:3];
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_job(8'd1, 4'd3);
    checks++;
    if (done_cyc !== 5) begin errors++; $display("FAIL basic_latency: got %0d, required 5", done_cyc); end
    checks++;
    if (result !== 8'd4 || ovf !== 1'b0) begin
      errors++; $display("FAIL basic_result: result=%0d ovf=%b, required 4/0", result, ovf);
    end
    checks++;
    if (busy_cyc !== 5) begin errors++; $display("FAIL basic_busy: %0d cycles, required 5", busy_cyc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_hist[i+2] !== exp_q[i]) begin
        errors++; $display("FAIL basic_accq[%0d]: got %0d, required %0d", i, acc_hist[i+2], exp_q[i]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after: busy=%b done=%b, required 0/0", busy, done);
    end
    checks++;
    if (result !== 8'd4) begin errors++; $display("FAIL basic_result_hold: got %0d, required 4", result); end
  endtask

  task automatic test_wrap();
    run_job(8'd200, 4'd1);
    checks++;
    if (done_cyc !== 3) begin errors++; $display("FAIL wrap_latency: got %0d, required 3", done_cyc); end
    checks++;
    if (result !== 8'd144 || ovf !== 1'b1) begin
      errors++; $display("FAIL wrap_result: result=%0d ovf=%b, required 144/1", result, ovf);
    end
    tick();
  endtask

  task automatic test_zero_count();
    run_job(8'h5A, 4'd0);
    checks++;
    if (done_cyc !== 2) begin errors++; $display("FAIL zero_latency: got %0d, required 2", done_cyc); end
    checks++;
    if (result !== 8'h5A || ovf !== 1'b0) begin
      errors++; $display("FAIL zero_result: result=%h ovf=%b, required 5a/0", result, ovf);
    end
    checks++;
    if (ld_cyc !== 1) begin errors++; $display("FAIL zero_ldacc_cycles: got %0d, required 1", ld_cyc); end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; din = 8'd2; count = 4'd4;
    tick();
    start = 1'b0;
    tick();
    // Second request arrives during ADD and must be dropped.
    start = 1'b1; din = 8'd7; count = 4'd1;
    tick();
    start = 1'b0;
    done_cyc = -1;
    for (int c = 3; c <= 20; c++) begin
      if (done) begin done_cyc = c; break; end
      tick();
    end
    checks++;
    if (done_cyc !== 6) begin errors++; $display("FAIL b2b_latency: got %0d, required 6", done_cyc); end
    checks++;
    if (result !== 8'd10) begin errors++; $display("FAIL b2b_result: got %0d, required 10", result); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
    run_job(8'd5, 4'd0);
    checks++;
    if (done_cyc !== 2 || result !== 8'd5) begin
      errors++; $display("FAIL b2b_next_job: done at %0d result=%0d, required 2/5", done_cyc, result);
    end
    tick();
  endtask

  task automatic test_reset_midjob();
    start = 1'b1; din = 8'd200; count = 4'd5;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midjob_pre: ovf=%b busy=%b, required 1/1", ovf, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, ldacc, en, ovf} !== 5'b0 || result !== 8'd0) begin
      errors++;
      $display("FAIL midjob_reset: busy=%b done=%b ldacc=%b en=%b ovf=%b result=%0d, required all 0",
               busy, done, ldacc, en, ovf, result);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midjob_stay_idle: busy=%b, required 0", busy); end
    run_job(8'd3, 4'd2);
    checks++;
    if (done_cyc !== 4 || result !== 8'd9) begin
      errors++; $display("FAIL midjob_next_job: done at %0d result=%0d, required 4/9", done_cyc, result);
    end
    tick();
  endtask

  task automatic test_max_count();
    run_job(8'd20, 4'd15);
    checks++;
    if (done_cyc !== 17) begin errors++; $display("FAIL max_latency: got %0d, required 17", done_cyc); end
    checks++;
    if (result !== 8'd64 || ovf !== 1'b1) begin
      errors++; $display("FAIL max_result: result=%0d ovf=%b, required 64/1", result, ovf);
    end
    checks++;
    if (busy_cyc !== 17) begin errors++; $display("FAIL max_busy: %0d cycles, required 17", busy_cyc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_back_to_back();
    test_reset_midjob();
    test_max_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc8bit_ctrl.md
Name: acc8bit_ctrl

Overview:
Sequencing controller that drives an external 8-bit accumulator register (inputs D, ldacc, en; output Q). It is the initiating end of the accumulator's load interface.
- On a start request it loads an operand into the accumulator.
- It then repeatedly adds the same operand to the fed-back Q a programmed number of times.
- It presents the final value with a one-cycle done strobe.
- It sits between the datapath operand source and the accumulator register.

Parameters:
WIDTH, 8, data width of operand, accumulator and result
CNTW, 4, width of the repeat-count input (max 2^CNTW-1 add steps)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
din  input  WIDTH  operand; captured on accepted start
count  input  CNTW  number of add steps; captured on accepted start
acc_q  input  WIDTH  accumulator Q, fed back
acc_d  output  WIDTH  value driven to accumulator D
ldacc  output  1  accumulator load strobe
en  output  1  accumulator clock enable
busy  output  1  high from accepted start through DONE inclusive
done  output  1  one-cycle strobe; result valid
result  output  WIDTH  registered final accumulator value; held until next done
ovf  output  1  sticky carry-out of any add step in current job; valid with done

Behaviour:
- Reset is synchronous, active-high, and uses clk/rst exactly as above. Reset effects:
  - state=IDLE.
  - op_reg, cnt_reg, result and ovf clear to 0.
  - ldacc, en, done and busy are 0; acc_d=0.
  - Reset mid-job aborts immediately; the accumulator content is left as-is.
- Registered state and counter; outputs decoded from state (Moore), except acc_d in ADD.
- States: IDLE, LOAD, ADD, DONE.
- IDLE:
  - ldacc=en=0, acc_d=0.
  - If start=1: op_reg<=din, cnt_reg<=count, ovf<=0 -> LOAD.
- LOAD (exactly 1 cycle):
  - en=1, ldacc=1, acc_d=op_reg, busy=1.
  - If cnt_reg==0 -> DONE, else -> ADD.
- ADD:
  - en=1, ldacc=1, acc_d = (acc_q + op_reg) mod 2^WIDTH (combinational), busy=1.
  - ovf<= ovf | carry-out.
  - cnt_reg decrements each cycle; when cnt_reg==1 -> DONE.
  - The ADD state therefore lasts exactly count cycles.
- DONE (exactly 1 cycle):
  - en=0, ldacc=0, busy=1, done=1.
  - result<=acc_q, captured at the end of this cycle; it is therefore visible the cycle after done.
  - To make result usable *with* done instead, result is loaded in the last LOAD/ADD cycle from acc_d. This is the required implementation: result<=acc_d whenever the next state is DONE.
  - -> IDLE.
- Timing: start accepted at edge 0; LOAD during cycle 1; ADD during cycles 2..count+1; done high in cycle count+2. Total latency start->done = count+2 cycles.
- start while busy (LOAD/ADD/DONE) is ignored, not queued. The earliest next acceptance is in the IDLE cycle after DONE.
- Changes on din/count after acceptance have no effect.
- Wrap-around: the sum truncates to WIDTH bits; ovf records that at least one wrap occurred.
- count = 2^CNTW-1 is legal; cnt_reg never underflows.
- acc_q is assumed to reflect the previous cycle's acc_d when ldacc=en=1, i.e. one-cycle register latency.

Test Plan:
- Bench includes a behavioural accumulator model (Q<=D when en&ldacc).
- din=1, count=3, start pulse:
  - acc_q sequence 1,2,3,4.
  - done at start+5 cycles.
  - result=4, ovf=0, busy high 5 cycles.
- din=8'd200, count=1 -> result=8'd144, ovf=1, done at start+3.
- din=8'h5A, count=0:
  - LOAD only; done at start+2.
  - result=8'h5A.
  - ldacc/en high exactly 1 cycle.
- Second start with din=7 during ADD of job din=2, count=4 -> ignored; result=10. A new start in the cycle after done is accepted.
- Reset mid-job:
  - Assert rst during ADD step 2.
  - Next cycle: state IDLE; busy, done, ldacc, en all 0; result=0, ovf=0.
  - Subsequent job din=3, count=2 gives result=9.
- count=15, din=8'd20 -> result = 320 mod 256 = 8'd64, ovf=1, done at start+17.
